tanh: RTL and testbench



---
 rtl/tanh_pkg.sv | 38 +++
 rtl/tanh_lut.sv | 21 ++
 rtl/tanh.sv | 77 +++++++
 tb/tb_tanh.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// rtl/tanh_pkg.sv - shared constants and knot table for the tanh unit
package tanh_pkg;

  localparam int BITWIDTH  = 18;
  localparam int FRAC_BITS = 12;
  localparam int SEG_BITS  = 5;
  localparam int OFS_BITS  = 9;

  // Knot values are non-negative and never exceed 4093, so 12 bits suffice.
  localparam int Y_BITS    = 12;
  localparam int KNOTS     = 33;
  localparam int PROD_BITS = Y_BITS + OFS_BITS;

  // Half an output LSB after the right shift by OFS_BITS.
  localparam int ROUND_HALF = 1 << (OFS_BITS - 1);

  // |x| >= 4.0 saturates to the last knot.
  localparam logic [BITWIDTH-1:0] SAT_THRESHOLD = 18'h04000;

  // round_half_up(4096 * tanh(k/8)) for k = 0..32.
  localparam logic [Y_BITS-1:0] KNOT_Y [KNOTS] = '{
    12'd0,    12'd509,  12'd1003, 12'd1468, 12'd1893, 12'd2272, 12'd2602, 12'd2883,
    12'd3119, 12'd3315, 12'd3475, 12'd3604, 12'd3707, 12'd3790, 12'd3856, 12'd3908,
    12'd3949, 12'd3981, 12'd4006, 12'd4026, 12'd4041, 12'd4053, 12'd4063, 12'd4070,
    12'd4076, 12'd4080, 12'd4084, 12'd4086, 12'd4089, 12'd4090, 12'd4091, 12'd4092,
    12'd4093
  };

  // First pipeline stage: everything needed to interpolate and restore the sign.
  typedef struct packed {
    logic                sign;
    logic                sat;
    logic [OFS_BITS-1:0] ofs;
    logic [Y_BITS-1:0]   y_lo;
    logic [Y_BITS-1:0]   y_hi;
  } stage1_t;

endpackage

// File: rtl/tanh_lut.sv
// rtl/tanh_lut.sv - combinational dual-read ROM of the tanh knot table
module tanh_lut
  import tanh_pkg::*;
(
  input  logic [SEG_BITS-1:0] seg,
  output logic [Y_BITS-1:0]   y_lo,
  output logic [Y_BITS-1:0]   y_hi
);

  logic [SEG_BITS:0] idx_lo;
  logic [SEG_BITS:0] idx_hi;

  // Read the knots bounding segment seg; seg = 31 reaches the extra 33rd knot.
  always_comb begin
    idx_lo = {1'b0, seg};
    idx_hi = idx_lo + (SEG_BITS + 1)'(1);
    y_lo   = KNOT_Y[idx_lo];
    y_hi   = KNOT_Y[idx_hi];
  end

endmodule

// File: rtl/tanh.sv
// rtl/tanh.sv - two-stage piecewise-linear fixed-point tanh
module tanh
  import tanh_pkg::*;
#(
  parameter int BITWIDTH = tanh_pkg::BITWIDTH
) (
  input  logic [BITWIDTH-1:0] operand,
  input  logic                clock,
  input  logic                reset,
  output logic [BITWIDTH-1:0] result
);

  logic                sign_in;
  logic [BITWIDTH-1:0] mag;
  logic                sat_in;
  logic [SEG_BITS-1:0] seg;
  logic [OFS_BITS-1:0] ofs;
  logic [Y_BITS-1:0]   y_lo;
  logic [Y_BITS-1:0]   y_hi;

  stage1_t             s1;

  logic [Y_BITS-1:0]   delta;
  logic [PROD_BITS-1:0] prod;
  logic [Y_BITS-1:0]   interp;
  logic [Y_BITS-1:0]   mag_out;
  logic [BITWIDTH-1:0] mag_ext;
  logic [BITWIDTH-1:0] signed_out;

  // Fold to magnitude; -0x20000 folds to itself, which still trips saturation.
  always_comb begin
    sign_in = operand[BITWIDTH-1];
    mag     = sign_in ? (~operand + BITWIDTH'(1)) : operand;
    sat_in  = (mag >= SAT_THRESHOLD);
    seg     = mag[FRAC_BITS+1:OFS_BITS];
    ofs     = mag[OFS_BITS-1:0];
  end

  tanh_lut u_lut (
    .seg  (seg),
    .y_lo (y_lo),
    .y_hi (y_hi)
  );

  // Stage 1: capture sign, saturation, segment offset and bounding knots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.sign <= sign_in;
      s1.sat  <= sat_in;
      s1.ofs  <= ofs;
      s1.y_lo <= y_lo;
      s1.y_hi <= y_hi;
    end
  end

  // Interpolate with round-half-up, saturate, then restore the sign.
  always_comb begin
    delta      = s1.y_hi - s1.y_lo;
    prod       = PROD_BITS'(delta) * PROD_BITS'(s1.ofs);
    interp     = Y_BITS'((prod + PROD_BITS'(ROUND_HALF)) >> OFS_BITS);
    mag_out    = s1.sat ? KNOT_Y[KNOTS-1] : (s1.y_lo + interp);
    mag_ext    = BITWIDTH'(mag_out);
    signed_out = s1.sign ? (~mag_ext + BITWIDTH'(1)) : mag_ext;
  end

  // Stage 2: registered signed result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else begin
      result <= signed_out;
    end
  end

endmodule

// File: tb/tb_tanh.sv
// tb/tb_tanh.sv - self-checking bench for the tanh unit
module tb_tanh;

  logic [17:0] operand;
  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] result;

  int passed = 0;
  int total  = 0;
  int knot [0:32];
  int sweep_res [0:40960];

  tanh dut (
    .operand (operand),
    .clock   (clock),
    .reset   (reset),
    .result  (result)
  );

  always #5 clock = ~clock;

  // Golden model straight from the rounding/interpolation rules.
  function automatic int golden(int x);
    int a, k, f, y;
    a = (x < 0) ? -x : x;
    if (a >= 16384) begin
      y = knot[32];
    end else begin
      k = a / 512;
      f = a % 512;
      y = knot[k] + ((knot[k+1] - knot[k]) * f + 256) / 512;
    end
    return (x < 0) ? -y : y;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int got;
    reset   = 1'b1;
    operand = 18'h2ABCD;
    #2;
    got = $signed(result);
    total++;
    if (got !== 0) $display("FAIL reset_async got %0d expected 0", got);
    else passed++;
    tick();
    tick();
    got = $signed(result);
    total++;
    if (got !== 0) $display("FAIL reset_held got %0d expected 0", got);
    else passed++;
  endtask

  task automatic test_latency();
    operand = 18'h01000;
    reset   = 1'b0;
    tick();
    total++;
    if (result !== 18'h00000) $display("FAIL latency_one_edge got %h expected 00000", result);
    else passed++;
    tick();
    total++;
    if (result !== 18'h00C2F) $display("FAIL latency_two_edges got %h expected 00c2f", result);
    else passed++;
  endtask

  task automatic test_knots();
    logic [17:0] ops  [8];
    logic [17:0] exps [8];
    int sx, got;
    ops  = '{18'h00800, 18'h3F000, 18'h00000, 18'h05000, 18'h1FFFF, 18'h20000, 18'h04000, 18'h00100};
    exps = '{18'h00765, 18'h3F3D1, 18'h00000, 18'h00FFD, 18'h00FFD, 18'h3F003, 18'h00FFD, 18'h000FF};
    for (int i = 0; i < 8; i++) begin
      operand = ops[i];
      tick();
      tick();
      total++;
      if (result !== exps[i]) $display("FAIL knot op=%h got %h expected %h", ops[i], result, exps[i]);
      else passed++;
      sx  = $signed(ops[i]);
      got = $signed(result);
      total++;
      if (got !== golden(sx)) $display("FAIL knot_model op=%h got %0d expected %0d", ops[i], got, golden(sx));
      else passed++;
    end
  endtask

  task automatic test_sweep();
    int  prev, got;
    bit  valid;
    real err;
    logic [17:0] drv;
    valid = 1'b0;
    prev  = 0;
    for (int x = -20480; x <= 20481; x++) begin
      drv     = x[17:0];
      operand = (x <= 20480) ? drv : 18'h00000;
      tick();
      if (valid) begin
        got = $signed(result);
        sweep_res[prev + 20480] = got;
        total++;
        if (got !== golden(prev)) $display("FAIL sweep x=%0d got %0d expected %0d", prev, got, golden(prev));
        else passed++;
        err = $itor(got) - 4096.0 * $tanh($itor(prev) / 4096.0);
        if (err < 0.0) err = -err;
        total++;
        if (err > 8.0) $display("FAIL accuracy x=%0d got %0d error %f limit 8", prev, got, err);
        else passed++;
      end
      prev  = x;
      valid = 1'b1;
    end
    for (int i = 1; i <= 40960; i++) begin
      total++;
      if (sweep_res[i] < sweep_res[i-1])
        $display("FAIL monotonic x=%0d got %0d below previous %0d", i - 20480, sweep_res[i], sweep_res[i-1]);
      else passed++;
    end
    for (int i = 0; i <= 20480; i++) begin
      total++;
      if (sweep_res[i] !== -sweep_res[40960 - i])
        $display("FAIL symmetry x=%0d got %0d expected %0d", i - 20480, sweep_res[i], -sweep_res[40960 - i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int x, prev, got;
    logic [17:0] drv;
    bit valid;
    valid = 1'b0;
    prev  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 3 == 0) x = $signed(18'($urandom));
      else            x = int'($urandom_range(0, 40000)) - 20000;
      drv     = x[17:0];
      operand = drv;
      tick();
      if (valid) begin
        got = $signed(result);
        total++;
        if (got !== golden(prev)) $display("FAIL stream i=%0d x=%0d got %0d expected %0d", i, prev, got, golden(prev));
        else passed++;
      end
      prev  = x;
      valid = 1'b1;
      if (i == 700 || i == 1900) begin
        #2;
        reset = 1'b1;
        #1;
        got = $signed(result);
        total++;
        if (got !== 0) $display("FAIL midstream_reset i=%0d got %0d expected 0", i, got);
        else passed++;
        #1;
        reset = 1'b0;
        prev  = 0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k <= 32; k++)
      knot[k] = $rtoi($floor(4096.0 * $tanh(k / 8.0) + 0.5));
    test_reset();
    test_latency();
    test_knots();
    test_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
